// File: rtl/sync_fifo_queue_pkg.sv
// Shared helpers for the FIFO queue slice.
// Provides a clog2 that never returns less than 1.
package sync_fifo_queue_pkg;

    // Smallest k >= 1 with 2**k >= n.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int k = 31; k >= 1; k--) begin
            if ((64'd1 << k) >= 64'(n)) begin
                r = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_queue.sv
// First-word-fall-through FIFO, N x W, valid/ready both sides.
// Ports: clk, rst, clk_en; push i_v/i_rdy/i; pop o_v/o_rdy/o.
module sync_fifo_queue
    import sync_fifo_queue_pkg::*;
#(
    parameter int W = 1,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         i_v,
    output logic         i_rdy,
    input  logic [W-1:0] i,
    output logic         o_v,
    input  logic         o_rdy,
    output logic [W-1:0] o
);

    localparam int PW = clog2_min1(N);
    localparam int CW = clog2_min1(N + 1);

    logic [W-1:0]  mem [N];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    assign i_rdy = (cnt != CW'(N));
    assign o_v   = (cnt != '0);
    assign o     = mem[rp];

    assign push = i_v && i_rdy && clk_en;
    assign pop  = o_v && o_rdy && clk_en;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int k = 0; k < N; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (push) begin
                mem[wp] <= i;
                wp      <= nxt(wp);
            end
            if (pop) begin
                rp <= nxt(rp);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_queue.sv
// Randomised/directed bench for sync_fifo_queue.
// Two instances: W=4,N=4 and W=8,N=3, checked against queues.
module tb_sync_fifo_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;

    logic       i_v4, i_rdy4, o_v4, o_rdy4;
    logic [3:0] i4, o4;
    logic       i_v3, i_rdy3, o_v3, o_rdy3;
    logic [7:0] i3, o3;

    logic [3:0] m4[$];
    logic [7:0] m3[$];
    logic [7:0] stream [10];
    int         sent;
    int         recv;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sync_fifo_queue #(.W(4), .N(4)) dut4 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_v(i_v4), .i_rdy(i_rdy4), .i(i4),
        .o_v(o_v4), .o_rdy(o_rdy4), .o(o4)
    );

    sync_fifo_queue #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_v(i_v3), .i_rdy(i_rdy3), .i(i3),
        .o_v(o_v3), .o_rdy(o_rdy3), .o(o3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags every cycle; head only while the model holds data.
    task automatic chk_state();
        chk("n4_i_rdy", 32'(i_rdy4), 32'(m4.size() != 4));
        chk("n4_o_v", 32'(o_v4), 32'(m4.size() != 0));
        if (m4.size() != 0) chk("n4_o", 32'(o4), 32'(m4[0]));
        chk("n3_i_rdy", 32'(i_rdy3), 32'(m3.size() != 3));
        chk("n3_o_v", 32'(o_v3), 32'(m3.size() != 0));
        if (m3.size() != 0) chk("n3_o", 32'(o3), 32'(m3[0]));
    endtask

    task automatic cycle();
        bit p4, q4, p3, q3;
        p4 = !rst && clk_en && i_v4 && (m4.size() < 4);
        q4 = !rst && clk_en && o_rdy4 && (m4.size() > 0);
        p3 = !rst && clk_en && i_v3 && (m3.size() < 3);
        q3 = !rst && clk_en && o_rdy3 && (m3.size() > 0);
        if (q3) begin
            chk("n3_stream", 32'(o3), 32'(stream[recv]));
            recv++;
        end
        @(posedge clk);
        if (rst) begin
            m4.delete();
            m3.delete();
        end else begin
            if (q4) void'(m4.pop_front());
            if (p4) m4.push_back(i4);
            if (q3) void'(m3.pop_front());
            if (p3) begin
                m3.push_back(i3);
                sent++;
            end
        end
        #1;
        chk_state();
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        i_v4 = 1'b1; i4 = 4'd9; o_rdy4 = 1'b0;
        i_v3 = 1'b1; i3 = 8'h5a; o_rdy3 = 1'b0;
        sent = 0; recv = 0;
        for (int k = 0; k < 10; k++) stream[k] = 8'($urandom);

        // Reset held with pushes requested: nothing stored.
        cycle();
        cycle();
        chk("rst_o4", 32'(o4), 32'd0);
        chk("rst_o3", 32'(o3), 32'd0);
        rst = 1'b0; i_v4 = 1'b0; i_v3 = 1'b0;
        cycle();
        chk("idle_o4", 32'(o4), 32'd0);

        // Fill N=4 with 1..4, then a refused 5.
        for (int k = 1; k <= 5; k++) begin
            i_v4 = 1'b1; i4 = 4'(k);
            cycle();
        end
        chk("full_rdy", 32'(i_rdy4), 32'd0);
        chk("full_head", 32'(o4), 32'd1);
        i_v4 = 1'b0; o_rdy4 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain", 32'(o4), 32'(k));
            cycle();
        end
        chk("drained_o_v", 32'(o_v4), 32'd0);

        // Simultaneous push/pop at count 2.
        o_rdy4 = 1'b0; i_v4 = 1'b1;
        i4 = 4'd1; cycle();
        i4 = 4'd2; cycle();
        o_rdy4 = 1'b1;
        i4 = 4'd3; cycle();
        i4 = 4'd4; cycle();
        chk("sim_head", 32'(o4), 32'd3);
        o_rdy4 = 1'b0;
        i4 = 4'd5; cycle();
        i4 = 4'd6; cycle();
        chk("sim_full", 32'(i_rdy4), 32'd0);
        // Full with both requests: only the pop happens.
        o_rdy4 = 1'b1; i4 = 4'd7; cycle();
        chk("full_both_rdy", 32'(i_rdy4), 32'd1);
        chk("full_both_head", 32'(o4), 32'd4);

        // Clock enable low: nothing commits.
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("cen_head", 32'(o4), 32'd4);
        clk_en = 1'b1; i_v4 = 1'b0;
        cycle();
        chk("cen_resume", 32'(o4), 32'd5);
        o_rdy4 = 1'b0;

        // Reset with two entries held.
        rst = 1'b1; cycle();
        rst = 1'b0;
        chk("mid_rst_o", 32'(o4), 32'd0);
        chk("mid_rst_o_v", 32'(o_v4), 32'd0);
        i_v4 = 1'b1; i4 = 4'd7; cycle();
        i_v4 = 1'b0;
        chk("post_rst_push", 32'(o4), 32'd7);

        // N=3 wrap-around with random duty.
        for (int c = 0; c < 400 && recv < 10; c++) begin
            i_v3 = (sent < 10) && ($urandom_range(0, 1) == 1);
            i3 = (sent < 10) ? stream[sent] : 8'h00;
            o_rdy3 = ($urandom_range(0, 2) != 0);
            cycle();
        end
        chk("n3_recv", 32'(recv), 32'd10);
        chk("n3_sent", 32'(sent), 32'd10);
        chk("n3_empty", 32'(o_v3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
